// File: rtl/bitwise_arbiter.sv
// bitwise_arbiter: two-requester round-robin arbiter and sequencer for the
// shared 16-bit bitwise/shift unit. It grants one requester, drives the
// combinational unit from registers for one cycle, captures the result and
// holds it on a response channel tagged with the requester ID.
//
// Optional build macro: BITWISE_ARB_STATUS_EN adds the rsp_zero/rsp_neg flags.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. reqN_ready is asserted only in IDLE and only for the granted
// requester. Once raised, rsp_valid stays high and rsp_* stay stable until
// the edge where rsp_ready is also high. rsp_ready has no effect while
// rsp_valid is low.
module bitwise_arbiter #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [2:0]        bu_op_sel,
  output logic [DATA_W-1:0] bu_a,
  output logic [DATA_W-1:0] bu_b,
  input  logic [RES_W-1:0]  bu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_id,
  output logic              rsp_err,
`ifdef BITWISE_ARB_STATUS_EN
  output logic              rsp_zero,
  output logic              rsp_neg,
`endif
  output logic [1:0]        dbg_state,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   grant0;
  logic   grant1;

  // Grant logic: a lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  // Next-state logic: IDLE -> EXEC on a grant, EXEC -> RESP always, RESP -> IDLE on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: latch operands at grant, capture the unit result in EXEC, retire on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bu_op_sel  <= 3'b000;
      bu_a       <= '0;
      bu_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            bu_op_sel  <= req0_op;
            bu_a       <= req0_a;
            bu_b       <= req0_b;
            rsp_id     <= 1'b0;
            last_grant <= 1'b0;
          end else if (grant1) begin
            bu_op_sel  <= req1_op;
            bu_a       <= req1_a;
            bu_b       <= req1_b;
            rsp_id     <= 1'b1;
            last_grant <= 1'b1;
          end
        end
        EXEC: begin
          rsp_result <= bu_result;
          rsp_err    <= (bu_op_sel == 3'b111);
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BITWISE_ARB_STATUS_EN
  // Status flags are taken from the same unit result captured in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_zero <= (bu_result == '0);
      rsp_neg  <= bu_result[RES_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Directed testbench for bitwise_arbiter. A small behavioural stand-in for
// the bitwise unit drives bu_result from the registered bu_* outputs.
module tb_bitwise_arbiter;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [2:0]        bu_op_sel;
  logic [DATA_W-1:0] bu_a, bu_b;
  logic [RES_W-1:0]  bu_result;
  logic              rsp_valid, rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_id, rsp_err;
`ifdef BITWISE_ARB_STATUS_EN
  logic              rsp_zero, rsp_neg;
`endif
  logic [1:0]        dbg_state;
  logic              busy;

  int tests_run;
  int tests_failed;

  bitwise_arbiter #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .bu_op_sel(bu_op_sel), .bu_a(bu_a), .bu_b(bu_b), .bu_result(bu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
`ifdef BITWISE_ARB_STATUS_EN
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
    .dbg_state(dbg_state), .busy(busy)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stand-in bitwise unit: operands sign-extended to RES_W.
  logic signed [RES_W-1:0] sa, sb;
  always_comb begin
    sa = {{(RES_W-DATA_W){bu_a[DATA_W-1]}}, bu_a};
    sb = {{(RES_W-DATA_W){bu_b[DATA_W-1]}}, bu_b};
    case (bu_op_sel)
      3'b000:  bu_result = sa & sb;
      3'b001:  bu_result = sa | sb;
      3'b010:  bu_result = sa ^ sb;
      3'b011:  bu_result = ~sa;
      3'b100:  bu_result = sa << bu_b[4:0];
      3'b101:  bu_result = sa >>> bu_b[4:0];
      3'b110:  bu_result = sa[RES_W-1] ? -sa : sa;
      default: bu_result = '0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    #3;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rsp: valid=%b result=%h id=%b err=%b required 0/0/0/0",
               rsp_valid, rsp_result, rsp_id, rsp_err);
    end
    tests_run++;
    if (bu_op_sel !== 3'b000 || bu_a !== 16'h0 || bu_b !== 16'h0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_bu: op=%b a=%h b=%h busy=%b state=%0d required 0/0/0/0/0",
               bu_op_sel, bu_a, bu_b, busy, dbg_state);
    end
    tick;
    tick;
    rst_n = 1'b1;
    // rsp_ready while idle must not start anything.
    rsp_ready = 1'b1;
    tick;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_rsp_ready: valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_single_req0;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 16'h00F0; req0_b = 16'h0FF0;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_grant: ready0=%b ready1=%b required 1/0", req0_ready, req1_ready);
    end
    tick;
    req0_valid = 1'b0;
    #1;
    tests_run++;
    if (req0_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== 2'd1 || bu_a !== 16'h00F0) begin
      tests_failed++;
      $display("FAIL single_exec: ready0=%b busy=%b valid=%b state=%0d bu_a=%h required 0/1/0/1/00f0",
               req0_ready, busy, rsp_valid, dbg_state, bu_a);
    end
    tick;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h000000F0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rsp: valid=%b result=%h id=%b err=%b required 1/000000f0/0/0",
               rsp_valid, rsp_result, rsp_id, rsp_err);
    end
    rsp_ready = 1'b1;
    tick;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 16'hFFF0; req1_b = 16'h0002;
    #1;
    tests_run++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_grant: ready0=%b ready1=%b required 0/1", req0_ready, req1_ready);
    end
    tick;
    req1_valid = 1'b0; req1_a = 16'h1234;
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'h0055; req0_b = 16'h00AA;
    tick;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFFFFFC || rsp_id !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1 || bu_a !== 16'hFFF0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h id=%b rdy=%b%b busy=%b bu_a=%h required 1/fffffffc/1/00/1/fff0",
                 i, rsp_valid, rsp_result, rsp_id, req0_ready, req1_ready, busy, bu_a);
      end
      tick;
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    tick;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: valid=%b busy=%b required 0/0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    logic             exp_id;
    logic [RES_W-1:0] exp_res;
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'd1; req0_b = 16'd2;
    req1_valid = 1'b1; req1_op = 3'b010; req1_a = 16'd3; req1_b = 16'd1;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id  = k[0];
      exp_res = exp_id ? 32'd2 : 32'd3;
      tests_run++;
      if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: ready0=%b ready1=%b required %b/%b",
                 k, req0_ready, req1_ready, !exp_id, exp_id);
      end
      tick;
      tests_run++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_exec[%0d]: rdy=%b%b busy=%b required 00/1", k, req0_ready, req1_ready, busy);
      end
      tick;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== exp_res) begin
        tests_failed++;
        $display("FAIL rr_rsp[%0d]: valid=%b id=%b result=%h required 1/%b/%h",
                 k, rsp_valid, rsp_id, rsp_result, exp_id, exp_res);
      end
      tick;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
  endtask

  task automatic test_operand_hold;
    req0_valid = 1'b1; req0_op = 3'b110; req0_a = 16'hFFF9; req0_b = 16'h0000;
    tick;
    req0_valid = 1'b0; req0_a = 16'd5; req0_op = 3'b000;
    tick;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd7 || bu_a !== 16'hFFF9 || bu_op_sel !== 3'b110) begin
      tests_failed++;
      $display("FAIL operand_hold: valid=%b result=%h bu_a=%h op=%b required 1/00000007/fff9/110",
               rsp_valid, rsp_result, bu_a, bu_op_sel);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_invalid_op;
    req1_valid = 1'b1; req1_op = 3'b111; req1_a = 16'd5; req1_b = 16'd5;
    tick;
    req1_valid = 1'b0;
    tick;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_err !== 1'b1 || rsp_id !== 1'b1) begin
      tests_failed++;
      $display("FAIL invalid_op: valid=%b result=%h err=%b id=%b required 1/00000000/1/1",
               rsp_valid, rsp_result, rsp_err, rsp_id);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b011; req0_a = 16'd0; req0_b = 16'd0;
    tick;
    req0_valid = 1'b0;
    tick;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'hFFFFFFFF || rsp_err !== 1'b0 || rsp_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL not_after_invalid: valid=%b result=%h err=%b id=%b required 1/ffffffff/0/0",
               rsp_valid, rsp_result, rsp_err, rsp_id);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    // Serve req0 so the arbiter would otherwise favour req1 on the next tie.
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'h00FF; req0_b = 16'h0F00;
    tick;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0 || bu_a !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_async: valid=%b busy=%b state=%0d bu_a=%h required 0/0/0/0000",
               rsp_valid, busy, dbg_state, bu_a);
    end
    tick;
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_rsp: valid=%b required 0", rsp_valid);
    end
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 16'd1; req0_b = 16'd2;
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 16'd4; req1_b = 16'd8;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_tie: ready0=%b ready1=%b required 1/0", req0_ready, req1_ready);
    end
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_after_op: valid=%b result=%h id=%b err=%b required 1/00000000/0/0",
               rsp_valid, rsp_result, rsp_id, rsp_err);
    end
`ifdef BITWISE_ARB_STATUS_EN
    tests_run++;
    if (rsp_zero !== 1'b1 || rsp_neg !== 1'b0) begin
      tests_failed++;
      $display("FAIL status_flags: zero=%b neg=%b required 1/0", rsp_zero, rsp_neg);
    end
`endif
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset;
    test_single_req0;
    test_backpressure;
    test_round_robin;
    test_operand_hold;
    test_invalid_op;
    test_reset_mid_op;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
